secded_stream_decoder: RTL and testbench

Parametrised, pipelined Hamming SECDED decoder for a stream of extended-Hamming codewords. Each codeword enters through a valid/ready handshake. The block corrects single-bit errors and flags double or uncorrectable errors. It also keeps saturating error counters and a sticky uncorrectable-error flag for board-level status display on LEDs and HEX digits. It is the clocked, width-generic successor of the fixed 13-bit (8 data bits) combinational decoder.

---
 rtl/secded_stream_decoder.sv | 151 +++++++++++++++
 tb/tb_secded_stream_decoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_stream_decoder.sv
// Two-stage pipelined extended-Hamming SECDED decoder on a valid/ready stream,
// with saturating error counters and a sticky uncorrectable-error flag.
module secded_stream_decoder #(
  parameter  int DATA_W  = 8,
  parameter  int COUNT_W = 16,
  localparam int P       = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W  = DATA_W + P + 1
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CODE_W-1:0]  out_code,
  output logic [P-1:0]       out_syndrome,
  output logic               out_1bit_err,
  output logic               out_2bit_err,
  input  logic               cnt_clear,
  output logic [COUNT_W-1:0] single_cnt,
  output logic [COUNT_W-1:0] double_cnt,
  output logic               sticky_2bit
);

  localparam logic [P-1:0]       MAX_POS = P'(CODE_W - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_adv;
  logic              s2_adv;
  logic [CODE_W-1:0] s1_code;
  logic [P-1:0]      s1_syn;
  logic              s1_par;
  logic [P-1:0]      in_syn;
  logic [CODE_W-1:0] fix_code;
  logic [DATA_W-1:0] fix_data;
  logic              fix_1;
  logic              fix_2;
  logic              xfer;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign xfer     = s2_valid && out_ready;

  always_comb begin
    in_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      for (int k = 0; k < P; k++) begin
        if (i[k]) in_syn[k] = in_syn[k] ^ in_code[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= in_syn;
        s1_par  <= ^in_code;
      end
    end
  end

  // Odd parity with an in-range syndrome is the only correctable case.
  always_comb begin
    fix_code = s1_code;
    fix_1    = 1'b0;
    fix_2    = 1'b0;
    unique case (1'b1)
      (s1_syn == '0) && !s1_par: begin
      end
      (s1_syn == '0) && s1_par: begin
        fix_code[0] = !s1_code[0];
        fix_1       = 1'b1;
      end
      (s1_syn != '0) && s1_par && (s1_syn <= MAX_POS): begin
        for (int i = 1; i < CODE_W; i++) begin
          if (s1_syn == P'(i)) fix_code[i] = !s1_code[i];
        end
        fix_1 = 1'b1;
      end
      default: fix_2 = 1'b1;
    endcase
  end

  always_comb begin
    int j;
    j        = 0;
    fix_data = '0;
    for (int i = 3; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        fix_data[j] = fix_code[i];
        j++;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      s2_valid     <= 1'b0;
      out_code     <= '0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_1bit_err <= 1'b0;
      out_2bit_err <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_code     <= fix_code;
        out_data     <= fix_data;
        out_syndrome <= s1_syn;
        out_1bit_err <= fix_1;
        out_2bit_err <= fix_2;
      end
    end
  end

  assign out_valid = s2_valid;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      single_cnt  <= '0;
      double_cnt  <= '0;
      sticky_2bit <= 1'b0;
    end else if (cnt_clear) begin
      single_cnt  <= '0;
      double_cnt  <= '0;
      sticky_2bit <= 1'b0;
    end else if (xfer) begin
      if (out_1bit_err && single_cnt != CNT_MAX)
        single_cnt <= single_cnt + 1'b1;
      if (out_2bit_err && double_cnt != CNT_MAX)
        double_cnt <= double_cnt + 1'b1;
      if (out_2bit_err)
        sticky_2bit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Bench for secded_stream_decoder: scoreboard model of the decoded stream,
// counter model at two counter widths, and directed handshake scenarios.
module tb_secded_stream_decoder;

  localparam int DW = 8;
  localparam int CW = 13;
  localparam int PW = 4;

  logic          clock     = 1'b0;
  logic          reset_L   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] in_code   = '0;

  logic          in_ready,  out_valid,  e1,  e2,  sticky;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_code;
  logic [PW-1:0] syn;
  logic [15:0]   scnt, dcnt;

  logic          in_ready2, out_valid2, e1_2, e2_2, sticky2;
  logic [DW-1:0] out_data2;
  logic [CW-1:0] out_code2;
  logic [PW-1:0] syn2;
  logic [1:0]    scnt2, dcnt2;

  secded_stream_decoder dut (
    .clock(clock), .reset_L(reset_L),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_code(out_code), .out_syndrome(syn),
    .out_1bit_err(e1), .out_2bit_err(e2),
    .cnt_clear(cnt_clear), .single_cnt(scnt), .double_cnt(dcnt),
    .sticky_2bit(sticky)
  );

  secded_stream_decoder #(.DATA_W(8), .COUNT_W(2)) dut2 (
    .clock(clock), .reset_L(reset_L),
    .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_code(out_code2), .out_syndrome(syn2),
    .out_1bit_err(e1_2), .out_2bit_err(e2_2),
    .cnt_clear(cnt_clear), .single_cnt(scnt2), .double_cnt(dcnt2),
    .sticky_2bit(sticky2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [CW-1:0] code;
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic          e1;
    logic          e2;
  } res_t;

  typedef struct {
    logic [CW-1:0] code;
    int            acc;
  } ent_t;

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ($countones(i) != 1) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // Syndrome as the XOR of the positions of all set bits.
  function automatic res_t ref_decode(input logic [CW-1:0] c);
    res_t r;
    int s;
    s = 0;
    for (int i = 1; i < CW; i++) if (c[i]) s ^= i;
    r.syn  = PW'(s);
    r.code = c;
    r.e1   = 1'b0;
    r.e2   = 1'b0;
    if (^c) begin
      if (s < CW) begin
        r.code[s] = ~c[s];
        r.e1 = 1'b1;
      end else r.e2 = 1'b1;
    end else if (s != 0) r.e2 = 1'b1;
    r.data = extract(r.code);
    return r;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j, s;
    c = '0;
    j = 0;
    s = 0;
    for (int i = 1; i < CW; i++) begin
      if ($countones(i) != 1) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int i = 1; i < CW; i++) if (c[i]) s ^= i;
    for (int k = 0; k < PW; k++) if (s[k]) c[1 << k] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [CW-1:0] mk(input logic [DW-1:0] d,
                                       input int a, input int b);
    logic [CW-1:0] c;
    c = encode(d);
    if (a >= 0) c[a] = ~c[a];
    if (b >= 0) c[b] = ~c[b];
    return c;
  endfunction

  ent_t q[$];
  int   m_s1, m_d1, m_s2, m_d2;
  logic m_st;
  logic exp_v, exp_rdy;
  res_t r;

  initial begin
    m_s1 = 0; m_d1 = 0; m_s2 = 0; m_d2 = 0; m_st = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_L) begin
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_data", out_data, 0);
        chk("rst out_code", out_code, 0);
        chk("rst syndrome", syn, 0);
        chk("rst flags", {e1, e2}, 0);
        chk("rst counters", {scnt, dcnt, sticky}, 0);
        chk("rst counters2", {scnt2, dcnt2, sticky2}, 0);
        q.delete();
        m_s1 = 0; m_d1 = 0; m_s2 = 0; m_d2 = 0; m_st = 1'b0;
      end else begin
        exp_v   = (q.size() > 0) && (cyc >= q[0].acc + 2);
        exp_rdy = !(q.size() == 2 && !out_ready);
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready2", in_ready2, exp_rdy);
        chk("out_valid", out_valid, exp_v);
        chk("out_valid2", out_valid2, exp_v);
        if (exp_v) begin
          r = ref_decode(q[0].code);
          chk("out_code", out_code, r.code);
          chk("out_data", out_data, r.data);
          chk("out_syndrome", syn, r.syn);
          chk("out_1bit_err", e1, r.e1);
          chk("out_2bit_err", e2, r.e2);
          chk("out_all2", {out_code2, out_data2, syn2, e1_2, e2_2},
              {r.code, r.data, r.syn, r.e1, r.e2});
        end
        chk("single_cnt", scnt, m_s1);
        chk("double_cnt", dcnt, m_d1);
        chk("sticky_2bit", sticky, m_st);
        chk("single_cnt2", scnt2, m_s2);
        chk("double_cnt2", dcnt2, m_d2);
        chk("sticky_2bit2", sticky2, m_st);
        if (cnt_clear) begin
          m_s1 = 0; m_d1 = 0; m_s2 = 0; m_d2 = 0; m_st = 1'b0;
        end else if (exp_v && out_ready) begin
          if (r.e1) begin
            if (m_s1 < 65535) m_s1++;
            if (m_s2 < 3) m_s2++;
          end
          if (r.e2) begin
            if (m_d1 < 65535) m_d1++;
            if (m_d2 < 3) m_d2++;
            m_st = 1'b1;
          end
        end
        if (exp_v && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back('{in_code, cyc});
      end
    end
  end

  logic [CW-1:0] wq[$];

  task automatic stream_words();
    int  idx;
    int  guard;
    bit  acc;
    idx   = 0;
    guard = 0;
    in_valid = 1'b1;
    in_code  = wq[0];
    while (idx < wq.size() && guard < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (idx < wq.size()) in_code = wq[idx];
      end
    end
    in_valid = 1'b0;
    chk("stream accepted all", idx, wq.size());
  endtask

  task automatic send(input logic [CW-1:0] c);
    wq = {c};
    stream_words();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [15:0] pat;
  res_t        lr;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_L = 1'b1;

    chk("model encode FF", encode(8'hFF), 13'h1EEE);
    lr = ref_decode(13'h1E6E);
    chk("model 1E6E", {lr.code, lr.data, lr.syn, lr.e1, lr.e2},
        {13'h1EEE, 8'hFF, 4'd7, 1'b1, 1'b0});
    lr = ref_decode(13'h0001);
    chk("model 0001", {lr.code, lr.data, lr.syn, lr.e1, lr.e2},
        {13'h0000, 8'h00, 4'd0, 1'b1, 1'b0});
    lr = ref_decode(13'h0028);
    chk("model 0028", {lr.syn, lr.e1, lr.e2}, {4'd6, 1'b0, 1'b1});
    lr = ref_decode(13'h0112);
    chk("model 0112", {lr.syn, lr.e1, lr.e2}, {4'd13, 1'b0, 1'b1});

    send(13'h1EEE);
    @(negedge clock);
    chk("lat +1 out_valid", out_valid, 0);
    @(negedge clock);
    chk("lat +2 out_valid", out_valid, 1);
    chk("lat +2 out_data", out_data, 8'hFF);
    chk("clean flags", {e1, e2, syn}, 0);
    @(posedge clock);
    #1;
    idle(3);

    send(13'h1E6E);
    idle(4);
    chk("lit single_cnt 1", scnt, 1);
    send(13'h0001);
    idle(4);
    chk("lit single_cnt 2", scnt, 2);
    send(13'h0028);
    idle(4);
    chk("lit sticky", sticky, 1);
    chk("lit double_cnt 1", dcnt, 1);
    send(13'h0112);
    idle(4);
    chk("lit double_cnt 2", dcnt, 2);

    wq = {mk(8'h00, -1, -1), mk(8'hA5, 3, -1), mk(8'h5A, 12, -1),
          mk(8'h3C, 0, 5), mk(8'hC3, 1, 2), mk(8'h81, 8, -1),
          mk(8'h7E, 0, -1), mk(8'h42, 6, 11)};
    stream_words();
    idle(4);

    out_ready = 1'b0;
    wq = {mk(8'h11, -1, -1), mk(8'h22, 9, -1), mk(8'h33, 4, 7),
          mk(8'h44, -1, -1)};
    fork
      stream_words();
      begin
        repeat (4) @(negedge clock);
        chk("stall in_ready", in_ready, 0);
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        chk("release in_ready", in_ready, 1);
      end
    join
    idle(6);

    pat = 16'b1011_0011_1000_1101;
    wq = {mk(8'h01, 2, -1), mk(8'h02, -1, -1), mk(8'h04, 10, 3),
          mk(8'h08, 7, -1), mk(8'h10, -1, -1), mk(8'h20, 0, -1),
          mk(8'h40, 5, 6), mk(8'h80, 12, -1), mk(8'hF0, -1, -1),
          mk(8'h0F, 11, -1)};
    fork
      stream_words();
      begin
        for (int i = 0; i < 24; i++) begin
          out_ready = pat[i % 16];
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);

    send(13'h0028);
    @(posedge clock);
    #1 cnt_clear = 1'b1;
    @(posedge clock);
    #1 cnt_clear = 1'b0;
    @(negedge clock);
    chk("clear double_cnt", dcnt, 0);
    chk("clear single_cnt", scnt, 0);
    chk("clear sticky", sticky, 0);
    chk("clear sticky2", sticky2, 0);
    @(posedge clock);
    #1;
    idle(3);

    wq = {mk(8'h12, 3, -1), mk(8'h34, 5, -1), mk(8'h56, 9, -1),
          mk(8'h78, 1, -1), mk(8'h9A, 0, -1)};
    stream_words();
    idle(5);
    chk("sat single_cnt2", scnt2, 3);
    chk("nosat single_cnt", scnt, 5);

    wq = {mk(8'hDE, -1, -1), mk(8'hAD, 4, -1), mk(8'hBE, 2, 9),
          mk(8'hEF, -1, -1), mk(8'h55, 6, -1), mk(8'hAA, -1, -1)};
    fork
      stream_words();
      begin
        repeat (3) @(posedge clock);
        #2 reset_L = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst data", {out_data, out_code, syn}, 0);
        chk("async rst flags", {e1, e2, sticky}, 0);
        chk("async rst counters", {scnt, dcnt, scnt2, dcnt2}, 0);
        repeat (2) @(posedge clock);
        #1 reset_L = 1'b1;
      end
    join
    idle(6);

    send(13'h1E6E);
    idle(4);
    chk("post-rst single_cnt", scnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
